pipe_mips32_ex: RTL and testbench
=================================

# pipe_mips32_ex

Execute stage of the 5-stage 32-bit MIPS pipeline. Sits between the ID/EX and EX/MEM pipeline registers. Consumes the decoded instruction, operands and sign-extended immediate from ID. Produces the EX/MEM register set (IR, ALU result, store data, type, branch condition) for the MEM stage and the taken-branch logic. Integer multiply runs on an iterative shift-add unit and back-pressures ID while busy.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MUL_CYCLES, 32, iterations of the shift-add multiplier; must equal XLEN.

Ports:
- clk1  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- halted  in  1  global HALTED flag; when 1, every register in this block holds.
- flush  in  1  taken branch from MEM; squashes this cycle's EX work.
- id_ex_valid  in  1  ID/EX register holds a real instruction.
- id_ex_ir  in  32  instruction word; opcode is [31:26].
- id_ex_npc  in  32  PC+1 of the instruction.
- id_ex_a  in  32  rs operand (already zeroed for r0).
- id_ex_b  in  32  rt operand (already zeroed for r0).
- id_ex_imm  in  32  sign-extended immediate.
- id_ex_type  in  3  RR_ALU=000, RM_ALU=001, LOAD=010, STORE=011, BRANCH=100, HALT=101.
- ex_busy  out  1  multiplier running; ID must hold all id_ex_* inputs stable.
- ex_mem_valid  out  1  EX/MEM holds a real instruction.
- ex_mem_ir  out  32  instruction word passed through.
- ex_mem_type  out  3  type passed through.
- ex_mem_aluout  out  32  ALU result, effective address, or branch target.
- ex_mem_b  out  32  store data (id_ex_b passed through).
- ex_mem_cond  out  1  branch condition (A == 0).

## Operation
Opcodes: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111.

Result selection:
- RR_ALU: A+B, A−B, A&B, A|B, SLT = signed(A)<signed(B) ? 1 : 0, MUL = low 32 bits of A×B.
- RM_ALU: ADDI A+Imm, SUBI A−Imm, SLTI = signed(A)<signed(Imm).
- Unknown opcode in RR_ALU or RM_ALU: aluout = 32'hFFFF_FFFF.
- LOAD/STORE: aluout = A+Imm. ex_mem_b = B.
- BRANCH: aluout = NPC+Imm. cond = (A == 0). The BEQZ/BNEQZ polarity is resolved downstream.
- HALT: aluout = 0. Type is passed through so WB can assert HALTED.
- Addition and subtraction wrap modulo 2^32. No overflow flag.
- cond = 0 for every non-BRANCH type.

Multiplier FSM (states IDLE, RUN):
- IDLE → RUN on a valid RR_ALU MUL when not flushed. Operands are latched, the iteration counter is cleared to 0, and ex_busy goes to 1. EX/MEM receives a bubble (valid=0).
- RUN: each edge performs one shift-add step and increments the counter. id_ex_* inputs are ignored.
- RUN → IDLE on the edge where the counter reaches MUL_CYCLES−1. The product and the latched IR/type are written to EX/MEM with valid=1, and ex_busy falls.
- flush=1 in RUN: abort, return to IDLE, and write a bubble.

Priority, highest first: rst, halted (hold everything), flush, normal operation.

## Timing
- Reset values: all ex_mem_* = 0, ex_mem_valid = 0, ex_busy = 0, state IDLE, counter 0.
- Non-MUL ops: 1-cycle latency. Inputs sampled at edge N appear on ex_mem_* after edge N.
- MUL: accepted at edge N. ex_busy is high after N through edge N+32. The result is visible after edge N+32. That is 33 cycles total and 32 bubbles.
- flush at edge N: ex_mem_valid=0 after N. The other ex_mem_* fields are don't-care.
- id_ex_valid=0: bubble written (valid=0) and the FSM is unaffected.
- Asserting rst mid-MUL aborts the multiply immediately, without a clock.
- halted asserted mid-MUL freezes the counter. The multiply resumes when halted clears.

## Configuration
- EX_FAST_MUL_EN defined: MUL is a single-cycle combinational multiply with the same latency as ADD. ex_busy is tied to 0. The FSM and MUL_CYCLES are unused.
- Undefined (default): the iterative multiplier and FSM above are used.

## Test plan
- Reset, then ADD with A=5, B=7, valid=1 → after 1 edge: aluout=12, valid=1, type=000, cond=0.
- SLTI with A=32'hFFFF_FFFE (−2), Imm=3 → aluout=1. SUB with A=0, B=1 → aluout=32'hFFFF_FFFF.
- BEQZ with A=0, NPC=10, Imm=−4 → aluout=6, cond=1. Repeat with A=9 → cond=0.
- MUL with A=32'h0001_0003, B=32'h0000_0005 → ex_busy high for 32 cycles, 32 bubbles, then aluout=32'h0005_000F with valid=1. With EX_FAST_MUL_EN defined, the same result arrives after 1 edge and ex_busy stays 0.
- MUL started, flush pulsed at iteration 10 → ex_busy falls after that edge, ex_mem_valid=0, and the next ADD completes normally.
- rst asserted at iteration 20 of a MUL, then halted=1 during a later LW → all outputs return to 0 immediately. While halted, ex_mem_* hold their values across 5 edges.

Source files
------------

// File: rtl/pipe_mips32_ex.sv
// pipe_mips32_ex: execute stage of the 5-stage MIPS32 pipeline with an iterative shift-add multiplier
//
// Ports: clk1/rst (async, active-high), halted freezes all state, flush squashes this cycle's work.
// id_ex_* come from the ID/EX register; ex_mem_* form the EX/MEM register; ex_busy stalls ID
// while a multiply is iterating.
// Build option: define EX_FAST_MUL_EN for a single-cycle combinational MUL (ex_busy tied to 0).
module pipe_mips32_ex #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            halted,
  input  logic            flush,
  input  logic            id_ex_valid,
  input  logic [31:0]     id_ex_ir,
  input  logic [XLEN-1:0] id_ex_npc,
  input  logic [XLEN-1:0] id_ex_a,
  input  logic [XLEN-1:0] id_ex_b,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic [2:0]      id_ex_type,
  output logic            ex_busy,
  output logic            ex_mem_valid,
  output logic [31:0]     ex_mem_ir,
  output logic [2:0]      ex_mem_type,
  output logic [XLEN-1:0] ex_mem_aluout,
  output logic [XLEN-1:0] ex_mem_b,
  output logic            ex_mem_cond
);
`ifdef EX_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);
  localparam logic [2:0] T_RR = 3'b000, T_RM = 3'b001, T_LD = 3'b010, T_ST = 3'b011, T_BR = 3'b100;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010, OP_OR = 6'b000011,
                         OP_SLT = 6'b000100, OP_MUL = 6'b000101, OP_ADDI = 6'b001010,
                         OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, step;
  logic valid_q, valid_d, cond_q, cond_d;
  logic [31:0] ir_q, ir_d;
  logic [2:0] type_q, type_d;
  logic [XLEN-1:0] alu_q, alu_d, b_q, b_d;
  logic [5:0] op;
  logic [XLEN-1:0] rr_res, rm_res, alu_res;
  logic cond_res, mul_start;
  assign op = id_ex_ir[31:26];
  assign rr_res = op == OP_ADD ? id_ex_a + id_ex_b :
                  op == OP_SUB ? id_ex_a - id_ex_b :
                  op == OP_AND ? id_ex_a & id_ex_b :
                  op == OP_OR  ? id_ex_a | id_ex_b :
                  op == OP_SLT ? XLEN'($signed(id_ex_a) < $signed(id_ex_b)) :
                  op == OP_MUL ? (FAST_MUL ? id_ex_a * id_ex_b : '1) : '1;
  assign rm_res = op == OP_ADDI ? id_ex_a + id_ex_imm :
                  op == OP_SUBI ? id_ex_a - id_ex_imm :
                  op == OP_SLTI ? XLEN'($signed(id_ex_a) < $signed(id_ex_imm)) : '1;
  assign alu_res = id_ex_type == T_RR ? rr_res :
                   id_ex_type == T_RM ? rm_res :
                   (id_ex_type == T_LD || id_ex_type == T_ST) ? id_ex_a + id_ex_imm :
                   id_ex_type == T_BR ? id_ex_npc + id_ex_imm : '0;
  assign cond_res = id_ex_type == T_BR && id_ex_a == '0;
  assign mul_start = !FAST_MUL && id_ex_valid && id_ex_type == T_RR && op == OP_MUL;
  // one shift-add iteration: add the multiplicand when the current multiplier LSB is set
  assign step = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    valid_d = valid_q;
    ir_d = ir_q;
    type_d = type_q;
    alu_d = alu_q;
    b_d = b_q;
    cond_d = cond_q;
    if (!halted) begin
      if (flush) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else if (state_q == RUN) begin
        acc_d = step;
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? IDLE : RUN;
        valid_d = cnt_q == LAST;
        alu_d = cnt_q == LAST ? step : alu_q;
        cond_d = 1'b0;
      end else begin
        // IR/type/B of a starting multiply are captured here and held until the product lands
        ir_d = id_ex_ir;
        type_d = id_ex_type;
        alu_d = alu_res;
        b_d = id_ex_b;
        cond_d = cond_res;
        valid_d = id_ex_valid && !mul_start;
        if (mul_start) begin
          state_d = RUN;
          cnt_d = '0;
          acc_d = '0;
          mcand_d = id_ex_a;
          mplier_d = id_ex_b;
        end
      end
    end
  end
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      valid_q <= 1'b0;
      ir_q <= '0;
      type_q <= '0;
      alu_q <= '0;
      b_q <= '0;
      cond_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      valid_q <= valid_d;
      ir_q <= ir_d;
      type_q <= type_d;
      alu_q <= alu_d;
      b_q <= b_d;
      cond_q <= cond_d;
    end
  end
`ifdef EX_FAST_MUL_EN
  assign ex_busy = 1'b0;
`else
  assign ex_busy = state_q == RUN;
`endif
  assign ex_mem_valid = valid_q;
  assign ex_mem_ir = ir_q;
  assign ex_mem_type = type_q;
  assign ex_mem_aluout = alu_q;
  assign ex_mem_b = b_q;
  assign ex_mem_cond = cond_q;
endmodule

// File: tb/tb_pipe_mips32_ex.sv
// tb_pipe_mips32_ex: table-driven and scoreboarded bench for the MIPS32 execute stage
module tb_pipe_mips32_ex;
  logic clk1 = 1'b0, rst = 1'b0, halted = 1'b0, flush = 1'b0, id_ex_valid = 1'b0;
  logic [31:0] id_ex_ir = '0, id_ex_npc = '0, id_ex_a = '0, id_ex_b = '0, id_ex_imm = '0;
  logic [2:0] id_ex_type = '0;
  logic ex_busy, ex_mem_valid, ex_mem_cond;
  logic [31:0] ex_mem_ir, ex_mem_aluout, ex_mem_b;
  logic [2:0] ex_mem_type;
  pipe_mips32_ex dut (
    .clk1(clk1), .rst(rst), .halted(halted), .flush(flush), .id_ex_valid(id_ex_valid),
    .id_ex_ir(id_ex_ir), .id_ex_npc(id_ex_npc), .id_ex_a(id_ex_a), .id_ex_b(id_ex_b),
    .id_ex_imm(id_ex_imm), .id_ex_type(id_ex_type), .ex_busy(ex_busy),
    .ex_mem_valid(ex_mem_valid), .ex_mem_ir(ex_mem_ir), .ex_mem_type(ex_mem_type),
    .ex_mem_aluout(ex_mem_aluout), .ex_mem_b(ex_mem_b), .ex_mem_cond(ex_mem_cond)
  );
  always #5 clk1 = ~clk1;
`ifdef EX_FAST_MUL_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = 32;
`endif
  localparam logic [2:0] RR = 3'b000, RM = 3'b001, LD = 3'b010, ST = 3'b011, BR = 3'b100, HT = 3'b101;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011,
                         SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001,
                         ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100, BNEQZ = 6'b001101,
                         BEQZ = 6'b001110, HLT = 6'b111111;
  typedef struct {
    logic [5:0] op;
    logic [2:0] ty;
    logic [31:0] a, b, imm, npc, alu;
    logic cond;
  } vec_t;
  typedef struct {
    logic [31:0] ir, alu, b;
    logic [2:0] ty;
    logic cond;
  } exp_t;
  vec_t tbl[18];
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  logic mon_en = 1'b1;
  function automatic logic [31:0] mk_ir(input logic [5:0] op);
    return {op, 26'h15A5A5A};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic set_in(input logic [5:0] op, input logic [2:0] ty, input logic [31:0] a, b, imm, npc,
                        input logic v);
    id_ex_ir = mk_ir(op);
    id_ex_type = ty;
    id_ex_a = a;
    id_ex_b = b;
    id_ex_imm = imm;
    id_ex_npc = npc;
    id_ex_valid = v;
  endtask
  task automatic push(input logic [5:0] op, input logic [2:0] ty, input logic [31:0] alu, b,
                      input logic cond);
    sb.push_back('{mk_ir(op), alu, b, ty, cond});
  endtask
  task automatic drive(input vec_t v);
    @(posedge clk1);
    #1;
    set_in(v.op, v.ty, v.a, v.b, v.imm, v.npc, 1'b1);
    push(v.op, v.ty, v.alu, v.b, v.cond);
  endtask
  task automatic count_busy(output int c, output int bub);
    c = 0;
    bub = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk1);
      if (!ex_busy) return;
      c++;
      if (ex_mem_valid) bub++;
    end
    $display("FAIL mul_timeout: ex_busy still high after 100 cycles");
    c = -1;
  endtask
  task automatic run_mul(input logic [31:0] a, b, p, input int exp_busy);
    int c, bub;
    drive('{MUL, RR, a, b, 32'd0, 32'd0, p, 1'b0});
    @(posedge clk1);
    count_busy(c, bub);
    id_ex_valid = 1'b0;
    chk("mul_busy_cycles", 64'(c), 64'(exp_busy));
    chk("mul_bubbles", 64'(bub), 64'd0);
  endtask
  always @(negedge clk1) begin
    if (mon_en && !rst && ex_mem_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got ir=%h alu=%h, expected no valid output", ex_mem_ir, ex_mem_aluout);
      end else begin
        e = sb.pop_front();
        if ({ex_mem_ir, ex_mem_type, ex_mem_aluout, ex_mem_b, ex_mem_cond} !== {e.ir, e.ty, e.alu, e.b, e.cond}) begin
          n_bad++;
          $display("FAIL sb_ex_mem: got ir=%h ty=%b alu=%h b=%h cond=%b, expected ir=%h ty=%b alu=%h b=%h cond=%b",
                   ex_mem_ir, ex_mem_type, ex_mem_aluout, ex_mem_b, ex_mem_cond, e.ir, e.ty, e.alu, e.b, e.cond);
        end
      end
    end
  end
  initial begin
    tbl[0]  = '{ADD,   RR, 32'd5,        32'd7,        32'd0,        32'd0,   32'd12,       1'b0};
    tbl[1]  = '{SUB,   RR, 32'd0,        32'd1,        32'd0,        32'd0,   32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{AND_,  RR, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,   32'hF000,     1'b0};
    tbl[3]  = '{OR_,   RR, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,   32'hFFF0,     1'b0};
    tbl[4]  = '{SLT,   RR, 32'hFFFFFFFE, 32'd3,        32'd0,        32'd0,   32'd1,        1'b0};
    tbl[5]  = '{SLT,   RR, 32'd3,        32'hFFFFFFFE, 32'd0,        32'd0,   32'd0,        1'b0};
    tbl[6]  = '{ADDI,  RM, 32'hFFFFFFFF, 32'h123,      32'd1,        32'd0,   32'd0,        1'b0};
    tbl[7]  = '{SUBI,  RM, 32'd10,       32'd0,        32'd3,        32'd0,   32'd7,        1'b0};
    tbl[8]  = '{SLTI,  RM, 32'hFFFFFFFE, 32'd0,        32'd3,        32'd0,   32'd1,        1'b0};
    tbl[9]  = '{6'b000110, RR, 32'd1,    32'd1,        32'd0,        32'd0,   32'hFFFFFFFF, 1'b0};
    tbl[10] = '{ADD,   RM, 32'd1,        32'd0,        32'd1,        32'd0,   32'hFFFFFFFF, 1'b0};
    tbl[11] = '{LW,    LD, 32'd0,        32'd9,        32'd5,        32'd0,   32'd5,        1'b0};
    tbl[12] = '{SW,    ST, 32'd200,      32'hDEADBEEF, 32'd8,        32'd0,   32'd208,      1'b0};
    tbl[13] = '{BEQZ,  BR, 32'd0,        32'd0,        32'hFFFFFFFC, 32'd10,  32'd6,        1'b1};
    tbl[14] = '{BEQZ,  BR, 32'd9,        32'd0,        32'hFFFFFFFC, 32'd10,  32'd6,        1'b0};
    tbl[15] = '{BNEQZ, BR, 32'd0,        32'd4,        32'd20,       32'd100, 32'd120,      1'b1};
    tbl[16] = '{HLT,   HT, 32'd5,        32'd6,        32'd0,        32'd0,   32'd0,        1'b0};
    tbl[17] = '{SUB,   RR, 32'h80000000, 32'd1,        32'd0,        32'd0,   32'h7FFFFFFF, 1'b0};
    #2 rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    chk("reset_flags", {ex_mem_valid, ex_busy, ex_mem_cond, ex_mem_type}, 64'd0);
    chk("reset_alu_ir", {ex_mem_aluout, ex_mem_ir}, 64'd0);
    chk("reset_b", 64'(ex_mem_b), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) drive(tbl[i]);
    @(posedge clk1);
    #1 id_ex_valid = 1'b0;
    set_in(MUL, RR, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0);
    @(posedge clk1);
    #1;
    chk("invalid_mul_busy", 64'(ex_busy), 64'd0);
    chk("invalid_bubble", 64'(ex_mem_valid), 64'd0);
    run_mul(32'h00010003, 32'h00000005, 32'h0005000F, MUL_BUSY);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_BUSY);
`ifndef EX_FAST_MUL_EN
    begin
      int c, bub;
      drive('{MUL, RR, 32'd7, 32'd6, 32'd0, 32'd0, 32'd42, 1'b0});
      @(posedge clk1);
      repeat (5) @(posedge clk1);
      #1 halted = 1'b1;
      repeat (10) @(posedge clk1);
      #1;
      chk("halt_mul_busy_hold", 64'(ex_busy), 64'd1);
      halted = 1'b0;
      count_busy(c, bub);
      id_ex_valid = 1'b0;
      chk("halt_mul_remaining", 64'(c), 64'd27);
    end
    @(posedge clk1);
    #1 set_in(MUL, RR, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1);
    @(posedge clk1);
    repeat (10) @(posedge clk1);
    #1;
    chk("flush_pre_busy", 64'(ex_busy), 64'd1);
    flush = 1'b1;
    @(posedge clk1);
    #1 flush = 1'b0;
    chk("flush_busy", 64'(ex_busy), 64'd0);
    chk("flush_bubble", 64'(ex_mem_valid), 64'd0);
    set_in(ADD, RR, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1);
    push(ADD, RR, 32'd3, 32'd2, 1'b0);
    @(posedge clk1);
    #1 set_in(MUL, RR, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1);
    @(posedge clk1);
    repeat (20) @(posedge clk1);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_mul_flags", {ex_mem_valid, ex_busy, ex_mem_cond, ex_mem_type}, 64'd0);
    chk("rst_mid_mul_alu_ir", {ex_mem_aluout, ex_mem_ir}, 64'd0);
    chk("rst_mid_mul_b", 64'(ex_mem_b), 64'd0);
    id_ex_valid = 1'b0;
    @(posedge clk1);
    #1 rst = 1'b0;
`endif
    drive('{LW, LD, 32'd100, 32'd55, 32'd4, 32'd0, 32'd104, 1'b0});
    @(posedge clk1);
    @(negedge clk1);
    #1 mon_en = 1'b0;
    halted = 1'b1;
    set_in(ADD, RR, 32'd8, 32'd8, 32'd0, 32'd0, 1'b1);
    repeat (5) @(posedge clk1);
    #1;
    chk("halt_hold_alu", 64'(ex_mem_aluout), 64'd104);
    chk("halt_hold_ir_ty", {ex_mem_ir, ex_mem_type}, {29'd0, mk_ir(LW), LD});
    chk("halt_hold_valid_b", {ex_mem_valid, ex_mem_b}, {31'd0, 1'b1, 32'd55});
    halted = 1'b0;
    id_ex_valid = 1'b0;
    @(posedge clk1);
    #1 mon_en = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
